mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between instruction fetch (IF) and the load/store path (lw, sw, lwr, swr) of the 2-stage core.
- Sequences each access as a req/ack transaction with the memory and returns read data to the winning requester.
- Round-robin arbitration on contention; watchdog on unanswered accesses.
- Drives a pipeline stall while any requester is waiting. Sits between the fetch/execute stages and the memory.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              err_src,
    output logic              stall
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY  = 2'd2;

    // Last busy cycle that may still see an ack before the access is aborted.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]        r_state;
    logic              r_last_d;
    logic [7:0]        r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic              r_err;
    logic              r_err_src;

    logic              w_busy;
    logic              w_grant_if;

    assign w_busy     = (r_state == S_IF_BUSY) || (r_state == S_D_BUSY);
    // Fetch wins when it is alone or when data was granted last.
    assign w_grant_if = if_req && (!d_req || r_last_d);

    assign mem_req   = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign err       = r_err;
    assign err_src   = r_err_src;
    assign stall     = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

    // Arbitration, memory handshake sequencing and watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_wait     <= 8'd0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            r_err_src  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if) begin
                        r_state  <= S_IF_BUSY;
                        r_addr   <= if_addr;
                        r_we     <= 1'b0;
                        r_last_d <= 1'b0;
                        r_wait   <= 8'd0;
                    end else if (d_req) begin
                        r_state  <= S_D_BUSY;
                        r_addr   <= d_addr;
                        r_we     <= d_we;
                        r_wdata  <= d_wdata;
                        r_last_d <= 1'b1;
                        r_wait   <= 8'd0;
                    end
                end
                S_IF_BUSY, S_D_BUSY: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                        if (r_state == S_IF_BUSY) begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end else begin
                            if (!r_we) begin
                                r_d_rdata <= mem_rdata;
                            end
                            r_d_valid <= 1'b1;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state   <= S_IDLE;
                        r_err     <= 1'b1;
                        r_err_src <= (r_state == S_D_BUSY);
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int MAX_WAIT = 15;

    logic        clk, rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, mem_req, mem_we, err, err_src, stall;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester-side view of memory contents and bus-side memory image.
    logic [31:0] written   [bit [31:0]];
    logic [31:0] mem_store [bit [31:0]];
    logic [31:0] exp_if, exp_d;
    logic        exp_src;
    bit          last_d;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .err_src(err_src), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return written.exists(a) ? written[a] : dflt(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : dflt(a);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        exp_if = '0; exp_d = '0; exp_src = 1'b0; last_d = 1'b1;
    endtask

    // One access from IDLE; both requesters may contend, loser is withdrawn afterwards.
    task automatic access(input bit rq_if, input bit rq_d, input bit we,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] wd, input int delay);
        bit          g_if;
        logic [31:0] a, exp_rd;
        g_if   = rq_if && (!rq_d || last_d);
        a      = g_if ? ia : da;
        exp_rd = model_rd(a);
        if_req = rq_if; if_addr = ia;
        d_req = rq_d; d_we = we; d_addr = da; d_wdata = wd;
        #1;
        chk1("stall_on_req", stall, 1'b1);
        cycle();
        last_d = !g_if;
        chk1("grant_mem_req", mem_req, 1'b1);
        chk32("grant_addr", mem_addr, a);
        chk1("grant_we", mem_we, g_if ? 1'b0 : we);
        if (!g_if && we) chk32("grant_wdata", mem_wdata, wd);
        for (int i = 0; i < delay; i++) begin
            cycle();
            chk1("wait_mem_req", mem_req, 1'b1);
            chk1("wait_stall", stall, 1'b1);
        end
        mem_ack = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        if (mem_we) mem_store[mem_addr] = mem_wdata;
        cycle();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (g_if) exp_if = exp_rd;
        else if (!we) exp_d = exp_rd;
        else written[da] = wd;
        chk1("valid_if", if_valid, g_if);
        chk1("valid_d", d_valid, !g_if);
        chk1("done_mem_req", mem_req, 1'b0);
        chk1("done_err", err, 1'b0);
        chk1("done_err_src", err_src, exp_src);
        chk32("if_rdata", if_rdata, exp_if);
        chk32("d_rdata", d_rdata, exp_d);
        if (rq_if == g_if && rq_d == !g_if) chk1("stall_valid_cycle", stall, 1'b0);
        if_req = 1'b0; d_req = 1'b0;
        cycle();
        chk1("after_if_valid", if_valid, 1'b0);
        chk1("after_d_valid", d_valid, 1'b0);
        chk1("after_mem_req", mem_req, 1'b0);
    endtask

    // Access left unanswered, or answered on busy cycle ack_at (0 = never).
    task automatic watchdog(input bit is_if, input int ack_at);
        int          n;
        logic [31:0] a;
        a = 32'h1C0;
        if (is_if) begin if_req = 1'b1; if_addr = a; end
        else begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
        cycle();
        last_d = !is_if;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            if (n == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = mem_rd(mem_addr);
            end
            cycle();
            mem_ack = 1'b0;
        end
        if (ack_at != 0) begin
            if (is_if) exp_if = model_rd(a); else exp_d = model_rd(a);
            chki("wd_ack_busy_cycles", n, ack_at);
            chk1("wd_ack_err", err, 1'b0);
            chk1("wd_ack_valid", is_if ? if_valid : d_valid, 1'b1);
        end else begin
            exp_src = !is_if;
            chki("wd_busy_cycles", n, MAX_WAIT);
            chk1("wd_err", err, 1'b1);
            chk1("wd_if_valid", if_valid, 1'b0);
            chk1("wd_d_valid", d_valid, 1'b0);
        end
        chk1("wd_err_src", err_src, exp_src);
        chk32("wd_if_rdata", if_rdata, exp_if);
        chk32("wd_d_rdata", d_rdata, exp_d);
        if_req = 1'b0; d_req = 1'b0;
        cycle();
        chk1("wd_err_cleared", err, 1'b0);
        chk1("wd_mem_req_idle", mem_req, 1'b0);
        chk1("wd_err_src_held", err_src, exp_src);
    endtask

    initial begin
        logic [31:0] rd;
        bit          want_if;
        int          mode;

        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; d_addr = 32'h80; d_wdata = '0; mem_rdata = '0;
        exp_if = '0; exp_d = '0; exp_src = 1'b0; last_d = 1'b1;

        // Reset held with a pending data request.
        d_req = 1'b1;
        cycle();
        cycle();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_d_valid", d_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_err_src", err_src, 1'b0);
        chk1("rst_stall", stall, 1'b1);
        d_req = 1'b0;
        rst = 1'b1;
        cycle();
        access(0, 1, 0, 32'h0, 32'h80, 32'h0, 0);

        // Single fetch, ack two cycles after mem_req rises.
        written[32'h40] = 32'h2400_0005;
        mem_store[32'h40] = 32'h2400_0005;
        access(1, 0, 0, 32'h40, 32'h0, 32'h0, 2);
        chk32("fetch_rdata", if_rdata, 32'h2400_0005);

        // Store then load of the same word.
        rd = d_rdata;
        access(0, 1, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 1);
        chk32("store_keeps_d_rdata", d_rdata, rd);
        access(0, 1, 0, 32'h0, 32'h100, 32'h0, 0);
        chk32("load_rdata", d_rdata, 32'hDEAD_BEEF);

        // Watchdog: data abort, data ack on last cycle, fetch abort.
        watchdog(0, 0);
        watchdog(0, MAX_WAIT);
        watchdog(1, 0);

        // Reset in the middle of a store; a stray ack afterwards is ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h140; d_wdata = 32'h1234_5678;
        cycle();
        chk1("midrst_busy", mem_req, 1'b1);
        do_reset();
        chk1("midrst_mem_req", mem_req, 1'b0);
        chk1("midrst_d_valid", d_valid, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk32("midrst_d_rdata", d_rdata, 32'h0);
        chk1("midrst_err_src", err_src, 1'b0);
        rst = 1'b1; d_req = 1'b0; mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        chk1("midrst_stray_d_valid", d_valid, 1'b0);
        chk1("midrst_stray_mem_req", mem_req, 1'b0);
        cycle();
        chk1("midrst_late_d_valid", d_valid, 1'b0);
        chk1("midrst_late_err", err, 1'b0);
        chk1("midrst_late_if_valid", if_valid, 1'b0);

        // Contention from reset with immediate acks: IF, data, IF, data.
        do_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        cycle();
        for (int k = 0; k < 4; k++) begin
            want_if = (k % 2 == 0);
            chk1("cont_mem_req", mem_req, 1'b1);
            chk32("cont_addr", mem_addr, want_if ? 32'h200 : 32'h300);
            rd = $urandom;
            mem_ack = 1'b1; mem_rdata = rd;
            cycle();
            mem_ack = 1'b0;
            if (want_if) exp_if = rd; else exp_d = rd;
            chk1("cont_if_valid", if_valid, want_if);
            chk1("cont_d_valid", d_valid, !want_if);
            chk1("cont_idle_bubble", mem_req, 1'b0);
            chk32("cont_if_rdata", if_rdata, exp_if);
            chk32("cont_d_rdata", d_rdata, exp_d);
            if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
            cycle();
        end
        last_d = 1'b1;
        chk1("cont_end_idle", mem_req, 1'b0);

        // Randomized traffic against the requester-level model.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                watchdog($urandom_range(0, 1) == 1, $urandom_range(0, MAX_WAIT));
            end else begin
                mode = $urandom_range(0, 2);
                access(mode != 1, mode != 0, $urandom_range(0, 1) == 1,
                       32'($urandom_range(0, 7)) << 2, 32'($urandom_range(0, 7)) << 2,
                       $urandom, $urandom_range(0, 4));
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                cycle();
                mem_ack = 1'b0;
                chk1("idle_ack_if_valid", if_valid, 1'b0);
                chk1("idle_ack_d_valid", d_valid, 1'b0);
                chk1("idle_ack_mem_req", mem_req, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
